// File: rtl/fifo_push_compactor_4w_if.sv
// Lane-group input, FIFO write strobes and FIFO space flags for fifo_push_compactor_4w.
// The slave modport is the compactor; the master modport is its environment (upstream and FIFO).
interface fifo_push_compactor_4w_if #(
  parameter int unsigned DWIDTH = 32
);
  logic [3:0]        in_valid;
  logic [DWIDTH-1:0] in_data0;
  logic [DWIDTH-1:0] in_data1;
  logic [DWIDTH-1:0] in_data2;
  logic [DWIDTH-1:0] in_data3;
  logic              in_ready;
  logic              push0;
  logic              push1;
  logic              push2;
  logic              push3;
  logic [DWIDTH-1:0] push_data0;
  logic [DWIDTH-1:0] push_data1;
  logic [DWIDTH-1:0] push_data2;
  logic [DWIDTH-1:0] push_data3;
  logic              fifo_full;
  logic              fifo_1left_to_full;
  logic              fifo_2left_to_full;
  logic              fifo_3left_to_full;
  logic              busy;

  modport slave (
    input  in_valid, in_data0, in_data1, in_data2, in_data3,
    input  fifo_full, fifo_1left_to_full, fifo_2left_to_full, fifo_3left_to_full,
    output in_ready, busy,
    output push0, push1, push2, push3,
    output push_data0, push_data1, push_data2, push_data3
  );

  modport master (
    output in_valid, in_data0, in_data1, in_data2, in_data3,
    output fifo_full, fifo_1left_to_full, fifo_2left_to_full, fifo_3left_to_full,
    input  in_ready, busy,
    input  push0, push1, push2, push3,
    input  push_data0, push_data1, push_data2, push_data3
  );
endinterface

// File: rtl/fifo_push_compactor_4w.sv
// Compacts a sparse 4-lane group into contiguous FIFO pushes limited by free space;
// entries that do not fit are staged and drained on later cycles.
module fifo_push_compactor_4w #(
  parameter int unsigned DWIDTH = 32
) (
  input logic                     clk,
  input logic                     rst_n,
  fifo_push_compactor_4w_if.slave bus
);

  logic [2:0]        pend_cnt;
  logic [DWIDTH-1:0] pend     [4];
  logic              rst_done;

  logic [DWIDTH-1:0] lane     [4];
  logic [DWIDTH-1:0] comp     [4];
  logic [2:0]        n_valid;
  logic [DWIDTH-1:0] src      [4];
  logic [2:0]        src_cnt;
  logic [2:0]        free;
  logic [2:0]        npush;
  logic [DWIDTH-1:0] shifted  [4];
  logic [DWIDTH-1:0] pdata    [4];
  logic [3:0]        push;
  logic              in_ready_w;

  assign lane[0] = bus.in_data0;
  assign lane[1] = bus.in_data1;
  assign lane[2] = bus.in_data2;
  assign lane[3] = bus.in_data3;

  assign in_ready_w = rst_done & (pend_cnt == 3'd0);

  always_comb begin
    if (bus.fifo_full)               free = 3'd0;
    else if (bus.fifo_1left_to_full) free = 3'd1;
    else if (bus.fifo_2left_to_full) free = 3'd2;
    else if (bus.fifo_3left_to_full) free = 3'd3;
    else                             free = 3'd4;
  end

  always_comb begin
    n_valid = '0;
    for (int unsigned i = 0; i < 4; i++) comp[i] = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bus.in_valid[i]) begin
        comp[n_valid[1:0]] = lane[i];
        n_valid            = n_valid + 3'd1;
      end
    end
  end

  // One datapath serves both modes: the source is the staging buffer while it
  // holds entries, otherwise the compacted input group (only when ready).
  always_comb begin
    if (pend_cnt != 3'd0) begin
      src     = pend;
      src_cnt = pend_cnt;
    end else if (in_ready_w) begin
      src     = comp;
      src_cnt = n_valid;
    end else begin
      for (int unsigned i = 0; i < 4; i++) src[i] = '0;
      src_cnt = '0;
    end
    npush = (src_cnt < free) ? src_cnt : free;
  end

  always_comb begin
    int unsigned idx;
    for (int unsigned i = 0; i < 4; i++) begin
      push[i]    = (3'(i) < npush);
      pdata[i]   = push[i] ? src[i] : '0;
      idx        = i + 32'(npush);
      shifted[i] = (idx < 4) ? src[idx[1:0]] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_cnt <= '0;
      rst_done <= 1'b0;
      for (int unsigned i = 0; i < 4; i++) pend[i] <= '0;
    end else begin
      rst_done <= 1'b1;
      pend_cnt <= src_cnt - npush;
      pend     <= shifted;
    end
  end

  assign bus.in_ready   = in_ready_w;
  assign bus.busy       = (pend_cnt != 3'd0);
  assign bus.push0      = push[0];
  assign bus.push1      = push[1];
  assign bus.push2      = push[2];
  assign bus.push3      = push[3];
  assign bus.push_data0 = pdata[0];
  assign bus.push_data1 = pdata[1];
  assign bus.push_data2 = pdata[2];
  assign bus.push_data3 = pdata[3];

endmodule

// File: tb/tb_fifo_push_compactor_4w.sv
// Bench for fifo_push_compactor_4w: fixed vector table, hand sequences for stall and
// reset corners, and a random soak checked against a reference queue of accepted lanes.
module tb_fifo_push_compactor_4w;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_push_compactor_4w_if #(.DWIDTH(DW)) bus ();
  fifo_push_compactor_4w #(.DWIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q [$];
  int unsigned   pend_m;
  bit            rst_done_m;
  int unsigned   np_m;
  int unsigned   cnt_m;
  logic [3:0]    push_v;
  logic [DW-1:0] pd [4];

  // flags encoding: [0]=full [1]=1left [2]=2left [3]=3left
  typedef struct {
    logic [3:0]    v;
    logic [DW-1:0] d [4];
    logic [3:0]    fl;
    logic          rdy;
    logic          bsy;
    logic [3:0]    push;
    logic [DW-1:0] pd [4];
  } vec_t;

  vec_t tbl [10];

  function automatic vec_t mk(logic [3:0] v, logic [DW-1:0] d0, logic [DW-1:0] d1,
                              logic [DW-1:0] d2, logic [DW-1:0] d3, logic [3:0] fl,
                              logic rdy, logic bsy, logic [3:0] push,
                              logic [DW-1:0] p0, logic [DW-1:0] p1,
                              logic [DW-1:0] p2, logic [DW-1:0] p3);
    vec_t r;
    r.v = v; r.fl = fl; r.rdy = rdy; r.bsy = bsy; r.push = push;
    r.d[0] = d0; r.d[1] = d1; r.d[2] = d2; r.d[3] = d3;
    r.pd[0] = p0; r.pd[1] = p1; r.pd[2] = p2; r.pd[3] = p3;
    return r;
  endfunction

  function automatic int unsigned free_of(logic [3:0] fl);
    if (fl[0]) return 0;
    if (fl[1]) return 1;
    if (fl[2]) return 2;
    if (fl[3]) return 3;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs, sample the combinational outputs and check them
  // against the reference model; acceptance feeds the queue, pushes drain it.
  task automatic apply(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic [3:0] fl);
    logic [DW-1:0] lanes [4];
    logic [DW-1:0] e;
    int unsigned free, cnt, np;
    bit rdy;
    lanes[0] = d0; lanes[1] = d1; lanes[2] = d2; lanes[3] = d3;
    bus.in_valid = v;
    bus.in_data0 = d0; bus.in_data1 = d1; bus.in_data2 = d2; bus.in_data3 = d3;
    bus.fifo_full          = fl[0];
    bus.fifo_1left_to_full = fl[1];
    bus.fifo_2left_to_full = fl[2];
    bus.fifo_3left_to_full = fl[3];
    #2;
    push_v = {bus.push3, bus.push2, bus.push1, bus.push0};
    pd[0] = bus.push_data0; pd[1] = bus.push_data1;
    pd[2] = bus.push_data2; pd[3] = bus.push_data3;

    free = free_of(fl);
    rdy  = rst_n && rst_done_m && (pend_m == 0);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    chk("busy", 64'(bus.busy), 64'(pend_m != 0));
    if (pend_m != 0) cnt = pend_m;
    else if (rdy) begin
      cnt = $countones(v);
      for (int k = 0; k < 4; k++) if (v[k]) exp_q.push_back(lanes[k]);
    end else cnt = 0;
    np = (cnt < free) ? cnt : free;
    chk("push_strobes", 64'(push_v), 64'((1 << np) - 1));
    for (int k = 0; k < 4; k++) begin
      if (k < int'(np)) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL stale_push: push_data%0d=%0h with nothing outstanding", k, pd[k]);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("push_data%0d", k), 64'(pd[k]), 64'(e));
        end
      end
    end
    if (!rst_n) for (int k = 0; k < 4; k++) chk($sformatf("rst_push_data%0d", k), 64'(pd[k]), 64'd0);
    np_m  = np;
    cnt_m = cnt;
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst_n) begin
      rst_done_m = 1'b1;
      pend_m     = cnt_m - np_m;
    end else begin
      rst_done_m = 1'b0;
      pend_m     = 0;
    end
    #1;
  endtask

  task automatic cycle(input logic [3:0] v, input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                       input logic [DW-1:0] d2, input logic [DW-1:0] d3, input logic [3:0] fl);
    apply(v, d0, d1, d2, d3, fl);
    advance();
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = mk(4'b1010, 0, 'hB, 0, 'hD, 4'b0000, 1, 0, 4'b0011, 'hB, 'hD, 0, 0);
    tbl[1] = mk(4'b1111, 'hA, 'hB, 'hC, 'hD, 4'b0100, 1, 0, 4'b0011, 'hA, 'hB, 0, 0);
    tbl[2] = mk(4'b1111, 'h99, 'h99, 'h99, 'h99, 4'b0000, 0, 1, 4'b0011, 'hC, 'hD, 0, 0);
    tbl[3] = mk(4'b0000, 0, 0, 0, 0, 4'b0000, 1, 0, 4'b0000, 0, 0, 0, 0);
    tbl[4] = mk(4'b0100, 0, 0, 'h55, 0, 4'b0001, 1, 0, 4'b0000, 0, 0, 0, 0);
    tbl[5] = mk(4'b0001, 'h77, 0, 0, 0, 4'b1000, 0, 1, 4'b0001, 'h55, 0, 0, 0);
    tbl[6] = mk(4'b1001, 'h11, 0, 0, 'h44, 4'b0010, 1, 0, 4'b0001, 'h11, 0, 0, 0);
    tbl[7] = mk(4'b0000, 0, 0, 0, 0, 4'b0000, 0, 1, 4'b0001, 'h44, 0, 0, 0);
    tbl[8] = mk(4'b0111, 'h21, 'h22, 'h23, 0, 4'b1000, 1, 0, 4'b0111, 'h21, 'h22, 'h23, 0);
    tbl[9] = mk(4'b1111, 'h31, 'h32, 'h33, 'h34, 4'b0000, 1, 0, 4'b1111, 'h31, 'h32, 'h33, 'h34);

    pend_m = 0; rst_done_m = 1'b0; np_m = 0; cnt_m = 0;
    rst_n = 1'b0;
    bus.in_valid = '0;
    bus.in_data0 = '0; bus.in_data1 = '0; bus.in_data2 = '0; bus.in_data3 = '0;
    bus.fifo_full = 1'b0; bus.fifo_1left_to_full = 1'b0;
    bus.fifo_2left_to_full = 1'b0; bus.fifo_3left_to_full = 1'b0;
    #1;

    // Reset held with a full mask offered
    for (int i = 0; i < 5; i++) cycle(4'hF, $urandom, $urandom, $urandom, $urandom, 4'h0);
    rst_n = 1'b1;
    apply(4'hF, 'hE0, 'hE1, 'hE2, 'hE3, 4'h0);
    chk("ready_after_release", 64'(bus.in_ready), 64'd0);
    advance();

    // Fixed vectors
    for (int i = 0; i < 10; i++) begin
      apply(tbl[i].v, tbl[i].d[0], tbl[i].d[1], tbl[i].d[2], tbl[i].d[3], tbl[i].fl);
      chk($sformatf("tbl%0d_ready", i), 64'(bus.in_ready), 64'(tbl[i].rdy));
      chk($sformatf("tbl%0d_busy", i), 64'(bus.busy), 64'(tbl[i].bsy));
      chk($sformatf("tbl%0d_push", i), 64'(push_v), 64'(tbl[i].push));
      for (int k = 0; k < 4; k++)
        if (tbl[i].push[k]) chk($sformatf("tbl%0d_data%0d", i, k), 64'(pd[k]), 64'(tbl[i].pd[k]));
      advance();
    end

    // Full stall with three entries pending, then one per cycle
    cycle(4'hF, 'hA1, 'hA2, 'hA3, 'hA4, 4'b0010);
    for (int i = 0; i < 10; i++) begin
      apply(4'hF, $urandom, $urandom, $urandom, $urandom, 4'b0001);
      chk("stall_busy", 64'(bus.busy), 64'd1);
      advance();
    end
    for (int i = 0; i < 3; i++) begin
      apply(4'h0, 0, 0, 0, 0, 4'b0010);
      chk($sformatf("stall_drain%0d", i), 64'(pd[0]), 64'('hA2 + i));
      advance();
    end
    cycle(4'h0, 0, 0, 0, 0, 4'h0);

    // Reset asserted while two entries are pending and being pushed
    cycle(4'hF, 'hB1, 'hB2, 'hB3, 'hB4, 4'b0100);
    apply(4'h0, 0, 0, 0, 0, 4'h0);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(bus.busy), 64'd0);
    chk("midrst_push", 64'({bus.push3, bus.push2, bus.push1, bus.push0}), 64'd0);
    chk("midrst_ready", 64'(bus.in_ready), 64'd0);
    exp_q.delete();
    pend_m = 0; rst_done_m = 1'b0; cnt_m = 0; np_m = 0;
    advance();
    cycle(4'hF, $urandom, $urandom, $urandom, $urandom, 4'h0);
    cycle(4'hF, $urandom, $urandom, $urandom, $urandom, 4'h0);
    rst_n = 1'b1;

    // Random soak
    for (int i = 0; i < 10000; i++) begin
      logic [3:0] fl;
      fl = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      cycle(4'($urandom), $urandom, $urandom, $urandom, $urandom, fl);
    end
    for (int i = 0; i < 3; i++) cycle(4'h0, 0, 0, 0, 0, 4'h0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
